// File: rtl/sync_fifo_if.sv
// sync_fifo_if: push/pop handshake bundle between a producer/consumer (master) and the FIFO (slave).
interface sync_fifo_if #(parameter int DSIZE = 8) ();
   logic [DSIZE-1:0] wdata;
   logic [DSIZE-1:0] rdata;
   logic winc;
   logic wfull;
   logic rinc;
   logic rempty;
   modport master(output wdata, winc, rinc, input wfull, rdata, rempty);
   modport slave(input wdata, winc, rinc, output wfull, rdata, rempty);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO of 2**ASIZE words.
module sync_fifo #(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4
) (
   input logic clk,
   input logic rst,
   sync_fifo_if.slave f
);
   logic [DSIZE-1:0] mem [2**ASIZE];
   logic [ASIZE:0] wptr;
   logic [ASIZE:0] rptr;
   logic push;
   logic pop;
   // Extra wrap bit distinguishes full from empty when the addresses coincide.
   assign f.rempty = wptr == rptr;
   assign f.wfull = (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]) && (wptr[ASIZE] != rptr[ASIZE]);
   assign push = f.winc && !f.wfull;
   assign pop = f.rinc && !f.rempty;
   assign f.rdata = mem[rptr[ASIZE-1:0]];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         wptr <= push ? wptr + 1'b1 : wptr;
         rptr <= pop ? rptr + 1'b1 : rptr;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wptr[ASIZE-1:0]] <= f.wdata;
   end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scenario tasks drive the FIFO against a queue model of its contents.
module tb_sync_fifo;
   localparam int DEPTH = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_checks = 0;
   int n_fail = 0;
   logic [7:0] sb [$];
   logic [7:0] got;
   logic [7:0] exp;
   logic popped;

   sync_fifo_if #(.DSIZE(8)) bus ();
   sync_fifo #(.DSIZE(8), .ASIZE(4)) dut (.clk(clk), .rst(rst), .f(bus));

   always #5 clk = ~clk;

   // One clock of stimulus; rdata sampled at the negedge before the edge that pops it.
   task automatic drive(input logic wi, input logic ri, input logic [7:0] wd,
                        output logic [7:0] g, output logic [7:0] e, output logic p);
      logic ok_push;
      bus.winc = wi;
      bus.rinc = ri;
      bus.wdata = wd;
      @(negedge clk);
      g = bus.rdata;
      p = ri && sb.size() > 0;
      e = p ? sb[0] : 8'h00;
      ok_push = wi && sb.size() < DEPTH;
      @(posedge clk);
      if (p) void'(sb.pop_front());
      if (ok_push) sb.push_back(wd);
      #1;
      bus.winc = 1'b0;
      bus.rinc = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.rempty !== 1'b1 || bus.wfull !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: rempty=%b wfull=%b required rempty=1 wfull=0", bus.rempty, bus.wfull);
      end
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.rempty !== 1'b1 || bus.wfull !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold: rempty=%b wfull=%b required rempty=1 wfull=0", bus.rempty, bus.wfull);
      end
   endtask

   task automatic test_basic();
      logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      foreach (vals[i]) begin
         drive(1'b1, 1'b0, vals[i], got, exp, popped);
         n_checks++;
         if (bus.rempty !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_rempty_after_push%0d: got %b required 0", i, bus.rempty);
         end
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 8'h00, got, exp, popped);
         if (popped) begin
            n_checks++;
            if (got !== exp) begin
               n_fail++;
               $display("FAIL basic_pop%0d: rdata=%h required %h", i, got, exp);
            end
         end
         n_checks++;
         if (bus.rempty !== (i >= 3)) begin
            n_fail++;
            $display("FAIL basic_rempty_pop%0d: got %b required %b", i, bus.rempty, i >= 3);
         end
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b0, 8'(8'h80 + i), got, exp, popped);
         n_checks++;
         if (bus.wfull !== (sb.size() == DEPTH)) begin
            n_fail++;
            $display("FAIL overflow_wfull_push%0d: got %b required %b", i, bus.wfull, sb.size() == DEPTH);
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 1'b1, 8'h00, got, exp, popped);
         n_checks++;
         if (got !== exp || !popped) begin
            n_fail++;
            $display("FAIL overflow_drain%0d: rdata=%h required %h", i, got, exp);
         end
      end
      n_checks++;
      if (bus.rempty !== 1'b1 || bus.wfull !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_end_flags: rempty=%b wfull=%b required 1 0", bus.rempty, bus.wfull);
      end
   endtask

   task automatic test_concurrent();
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(8'h50 + i), got, exp, popped);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, 8'(8'h60 + i), got, exp, popped);
         n_checks++;
         if (got !== exp || !popped) begin
            n_fail++;
            $display("FAIL concurrent_pop%0d: rdata=%h required %h", i, got, exp);
         end
         n_checks++;
         if (bus.rempty !== 1'b0 || bus.wfull !== 1'b0 || sb.size() != 5) begin
            n_fail++;
            $display("FAIL concurrent_flags%0d: rempty=%b wfull=%b required 0 0", i, bus.rempty, bus.wfull);
         end
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 8'h00, got, exp, popped);
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL concurrent_drain%0d: rdata=%h required %h", i, got, exp);
         end
      end
   endtask

   task automatic test_full_boundary();
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 8'(8'hC0 + i), got, exp, popped);
      n_checks++;
      if (bus.wfull !== 1'b1) begin
         n_fail++;
         $display("FAIL full_set: wfull=%b required 1", bus.wfull);
      end
      drive(1'b1, 1'b1, 8'hEE, got, exp, popped);
      n_checks++;
      if (got !== 8'hC0) begin
         n_fail++;
         $display("FAIL full_pushpop_rdata: rdata=%h required c0", got);
      end
      n_checks++;
      if (bus.wfull !== 1'b0) begin
         n_fail++;
         $display("FAIL full_after_pop: wfull=%b required 0", bus.wfull);
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
         drive(1'b0, 1'b1, 8'h00, got, exp, popped);
         n_checks++;
         if (got !== exp || !popped) begin
            n_fail++;
            $display("FAIL full_drain%0d: rdata=%h required %h", i, got, exp);
         end
      end
      n_checks++;
      if (bus.rempty !== 1'b1) begin
         n_fail++;
         $display("FAIL full_drain_empty: rempty=%b required 1", bus.rempty);
      end
   endtask

   task automatic test_wrap_reset();
      drive(1'b1, 1'b0, 8'h00, got, exp, popped);
      for (int i = 1; i < 40; i++) begin
         drive(1'b1, 1'b1, 8'(i * 7), got, exp, popped);
         n_checks++;
         if (got !== exp || !popped) begin
            n_fail++;
            $display("FAIL wrap_pop%0d: rdata=%h required %h", i, got, exp);
         end
      end
      drive(1'b0, 1'b1, 8'h00, got, exp, popped);
      n_checks++;
      if (got !== exp || bus.rempty !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_last: rdata=%h rempty=%b required %h 1", got, bus.rempty, exp);
      end
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'(8'h30 + i), got, exp, popped);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.rempty !== 1'b1 || bus.wfull !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: rempty=%b wfull=%b required 1 0", bus.rempty, bus.wfull);
      end
      sb.delete();
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      drive(1'b1, 1'b0, 8'hA5, got, exp, popped);
      drive(1'b0, 1'b1, 8'h00, got, exp, popped);
      n_checks++;
      if (got !== 8'hA5 || exp !== 8'hA5) begin
         n_fail++;
         $display("FAIL post_reset_readback: rdata=%h required a5", got);
      end
      n_checks++;
      if (bus.rempty !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_empty: rempty=%b required 1", bus.rempty);
      end
   endtask

   initial begin
      bus.winc = 1'b0;
      bus.rinc = 1'b0;
      bus.wdata = 8'h00;
      test_reset();
      test_basic();
      test_overflow();
      test_concurrent();
      test_full_boundary();
      test_wrap_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
